// File: rtl/hp_bus_pkg.sv
// Shared types and constants for the HP bus fabric.
//   state_t      : word-timing lock state (UNLOCKED / LOCKED)
//   WORD_LEN_DEF : default bit times per word
//   OWNER_W      : width of the registered owner field (winner index + 1)
//   IDX_W        : width of a source index (up to 8 sources)
//   BIT_IDX_W    : width of the bit-time counter
package hp_bus_pkg;

    localparam int unsigned WORD_LEN_DEF = 56;
    localparam int unsigned OWNER_W      = 4;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned BIT_IDX_W    = 6;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

endpackage

// File: rtl/hp_bus_prio_enc.sv
// Highest-index priority encoder.
//   req     : per-source qualified request
//   valid_c : at least one request set
//   multi_c : two or more requests set
//   idx_c   : index of the highest set request (0 when none)
module hp_bus_prio_enc
    import hp_bus_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]     req,
    output logic             valid_c,
    output logic             multi_c,
    output logic [IDX_W-1:0] idx_c
);

    // Ascending scan: the last hit seen is the highest index.
    always_comb begin
        valid_c = 1'b0;
        multi_c = 1'b0;
        idx_c   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
                if (valid_c) multi_c = 1'b1;
                valid_c = 1'b1;
                idx_c   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hp_bus_fabric.sv
// Internal bus fabric: mux-based resolution of N_SRC drivers with a bus
// keeper, contention statistics, and SYNC-locked word bit timing.
//   PHI2 / PWO            : clock / async active-high reset
//   src_active/drive/en   : per-source request, bit value, debug enable
//   ext_in                : external pin value used when nobody drives
//   sync_in, clr_stat     : global SYNC, clear statistics
//   bus_out, bus_oe       : resolved bus bit and pad enable (combinational)
//   owner                 : registered winner index+1 (0 = none)
//   contention(_cnt)      : sticky multi-driver flag and saturating count
//   bit_idx, locked       : bit time within word, lock status
//   word_err              : sticky SYNC misalignment flag
module hp_bus_fabric
    import hp_bus_pkg::*;
#(
    parameter int unsigned N_SRC    = 3,
    parameter int unsigned WORD_LEN = WORD_LEN_DEF,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned KEEP_CYC = 1
) (
    input  logic                 PHI2,
    input  logic                 PWO,
    input  logic [N_SRC-1:0]     src_active,
    input  logic [N_SRC-1:0]     src_drive,
    input  logic [N_SRC-1:0]     src_en,
    input  logic                 ext_in,
    input  logic                 sync_in,
    input  logic                 clr_stat,
    output logic                 bus_out,
    output logic                 bus_oe,
    output logic [OWNER_W-1:0]   owner,
    output logic                 contention,
    output logic [CNT_W-1:0]     contention_cnt,
    output logic [BIT_IDX_W-1:0] bit_idx,
    output logic                 locked,
    output logic                 word_err
);

    localparam int unsigned KEEP_W = (KEEP_CYC < 2) ? 1 : $clog2(KEEP_CYC + 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(WORD_LEN - 1);

    logic [N_SRC-1:0]     q_c;
    logic                 hit_c;
    logic                 multi_c;
    logic [IDX_W-1:0]     win_c;
    logic                 drive_c;
    logic                 sync_q;
    logic                 sync_rise_c;
    logic                 keep_val;
    logic [KEEP_W-1:0]    keep_cnt;
    state_t               state;
    state_t               state_nxt;
    logic [BIT_IDX_W-1:0] bit_idx_nxt;
    logic                 misalign_c;

    assign q_c = src_active & src_en;

    hp_bus_prio_enc #(.N(N_SRC)) u_prio (
        .req     (q_c),
        .valid_c (hit_c),
        .multi_c (multi_c),
        .idx_c   (win_c)
    );

    // Winner's drive value; same priority as the encoder (highest index wins).
    always_comb begin
        drive_c = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (q_c[i]) drive_c = src_drive[i];
        end
    end

    // Resolution: driver, else keeper while its hold lasts, else the pin.
    assign bus_oe  = hit_c;
    assign bus_out = hit_c ? drive_c : ((keep_cnt != '0) ? keep_val : ext_in);

    assign sync_rise_c = sync_in & ~sync_q;
    assign locked      = (state == LOCKED);

    // Word timing next-state logic.
    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        misalign_c  = 1'b0;
        case (state)
            UNLOCKED: begin
                bit_idx_nxt = '0;
                if (sync_rise_c) state_nxt = LOCKED;
            end
            LOCKED: begin
                if (sync_rise_c) begin
                    bit_idx_nxt = '0;
                    misalign_c  = (bit_idx != LAST_BIT);
                end else if (bit_idx == LAST_BIT) begin
                    bit_idx_nxt = '0;
                end else begin
                    bit_idx_nxt = bit_idx + BIT_IDX_W'(1);
                end
            end
            default: begin
                state_nxt   = UNLOCKED;
                bit_idx_nxt = '0;
            end
        endcase
    end

    // State, timing and keeper registers.
    always_ff @(posedge PHI2 or posedge PWO) begin
        if (PWO) begin
            state    <= UNLOCKED;
            bit_idx  <= '0;
            sync_q   <= 1'b0;
            keep_val <= 1'b0;
            keep_cnt <= '0;
            owner    <= '0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            sync_q  <= sync_in;
            owner   <= hit_c ? (OWNER_W'(win_c) + OWNER_W'(1)) : '0;
            if (hit_c) begin
                keep_val <= drive_c;
                keep_cnt <= KEEP_W'(KEEP_CYC);
            end else if (keep_cnt != '0) begin
                keep_cnt <= keep_cnt - KEEP_W'(1);
            end
        end
    end

    // Statistics; a new event in the clearing cycle is still recorded.
    always_ff @(posedge PHI2 or posedge PWO) begin
        if (PWO) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
            word_err       <= 1'b0;
        end else if (clr_stat) begin
            contention     <= multi_c;
            contention_cnt <= multi_c ? CNT_W'(1) : '0;
            word_err       <= misalign_c;
        end else begin
            if (multi_c) begin
                contention <= 1'b1;
                if (!(&contention_cnt)) contention_cnt <= contention_cnt + CNT_W'(1);
            end
            if (misalign_c) word_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hp_bus_fabric.sv
// Directed self-checking bench for hp_bus_fabric (scoreboard of expected values).
module tb_hp_bus_fabric;

    logic       PHI2 = 1'b0;
    logic       PWO;
    logic [2:0] src_active, src_drive, src_en;
    logic       ext_in, sync_in, clr_stat;
    logic       bus_out, bus_oe, contention, locked, word_err;
    logic [3:0] owner;
    logic [3:0] contention_cnt;
    logic [5:0] bit_idx;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    hp_bus_fabric #(
        .N_SRC(3), .WORD_LEN(56), .CNT_W(4), .KEEP_CYC(1)
    ) dut (
        .PHI2(PHI2), .PWO(PWO),
        .src_active(src_active), .src_drive(src_drive), .src_en(src_en),
        .ext_in(ext_in), .sync_in(sync_in), .clr_stat(clr_stat),
        .bus_out(bus_out), .bus_oe(bus_oe), .owner(owner),
        .contention(contention), .contention_cnt(contention_cnt),
        .bit_idx(bit_idx), .locked(locked), .word_err(word_err)
    );

    always #5 PHI2 = ~PHI2;

    task automatic step();
        @(posedge PHI2);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic chk(input logic [31:0] obs);
        logic [31:0] e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        push({tag, "_owner"}, 0);    chk(32'(owner));
        push({tag, "_cont"}, 0);     chk(32'(contention));
        push({tag, "_cnt"}, 0);      chk(32'(contention_cnt));
        push({tag, "_werr"}, 0);     chk(32'(word_err));
        push({tag, "_bit_idx"}, 0);  chk(32'(bit_idx));
        push({tag, "_locked"}, 0);   chk(32'(locked));
    endtask

    initial begin
        PWO = 1'b1; src_active = '0; src_drive = '0; src_en = 3'b111;
        ext_in = 1'b0; sync_in = 1'b0; clr_stat = 1'b0;
        #2;
        chk_reset_state("rst");

        // Reset does not block combinational resolution.
        ext_in = 1'b1; #1;
        push("rst_ext_out", 1); chk(32'(bus_out));
        push("rst_ext_oe", 0);  chk(32'(bus_oe));
        src_active = 3'b100; src_drive = 3'b000; #1;
        push("rst_drv_out", 0); chk(32'(bus_out));
        push("rst_drv_oe", 1);  chk(32'(bus_oe));
        src_active = '0; ext_in = 1'b0;
        #6 PWO = 1'b0;
        step();

        // Priority: q=011, drive=001 -> winner 1 drives 0.
        src_active = 3'b011; src_drive = 3'b001; #1;
        push("prio_out", 0); chk(32'(bus_out));
        push("prio_oe", 1);  chk(32'(bus_oe));
        step();
        push("prio_owner", 2); chk(32'(owner));
        push("prio_cont", 1);  chk(32'(contention));
        push("prio_cnt", 1);   chk(32'(contention_cnt));

        // Keeper: single driver of 1, then nobody with ext_in=0.
        src_active = 3'b010; src_drive = 3'b010; #1;
        push("keep_drv_out", 1); chk(32'(bus_out));
        step();
        push("keep_owner", 2); chk(32'(owner));
        push("keep_cnt", 1);   chk(32'(contention_cnt));
        src_active = '0; ext_in = 1'b0; #1;
        push("keep_hold_out", 1); chk(32'(bus_out));
        push("keep_hold_oe", 0);  chk(32'(bus_oe));
        step();
        push("keep_rel_out", 0); chk(32'(bus_out));
        push("keep_rel_oe", 0);  chk(32'(bus_oe));
        push("keep_owner0", 0);  chk(32'(owner));

        // Debug enable masks sources combinationally.
        src_active = 3'b111; src_drive = 3'b100; src_en = 3'b011; ext_in = 1'b1; #1;
        push("en_mask_out", 0); chk(32'(bus_out));
        src_en = 3'b111; #1;
        push("en_full_out", 1); chk(32'(bus_out));
        src_en = 3'b000; #1;
        push("en_none_oe", 0);  chk(32'(bus_oe));
        push("en_none_out", 1); chk(32'(bus_out));
        src_en = 3'b111; src_active = '0; ext_in = 1'b0;
        step();

        // Saturation: 20 contention cycles on a 4-bit counter.
        src_active = 3'b011;
        steps(20);
        push("sat_cnt", 15); chk(32'(contention_cnt));
        push("sat_cont", 1); chk(32'(contention));
        clr_stat = 1'b1;
        step();
        push("clr_hit_cnt", 1);  chk(32'(contention_cnt));
        push("clr_hit_cont", 1); chk(32'(contention));
        src_active = '0;
        step();
        push("clr_cnt", 0);  chk(32'(contention_cnt));
        push("clr_cont", 0); chk(32'(contention));
        clr_stat = 1'b0;

        // Lock and wrap.
        sync_in = 1'b1;
        step();
        push("lock_locked", 1); chk(32'(locked));
        push("lock_bit0", 0);   chk(32'(bit_idx));
        sync_in = 1'b0;
        steps(55);
        push("lock_bit55", 55); chk(32'(bit_idx));
        step();
        push("lock_wrap", 0);   chk(32'(bit_idx));
        push("lock_werr", 0);   chk(32'(word_err));

        // Misaligned SYNC at bit 20.
        steps(20);
        push("mis_bit20", 20); chk(32'(bit_idx));
        sync_in = 1'b1;
        step();
        push("mis_werr", 1);   chk(32'(word_err));
        push("mis_bit0", 0);   chk(32'(bit_idx));
        push("mis_locked", 1); chk(32'(locked));
        sync_in = 1'b0;
        step();
        push("mis_bit1", 1);   chk(32'(bit_idx));
        clr_stat = 1'b1;
        step();
        push("werr_clr", 0);   chk(32'(word_err));
        clr_stat = 1'b0;

        // Aligned SYNC at bit 55 is not an error.
        steps(53);
        push("al_bit55", 55);  chk(32'(bit_idx));
        sync_in = 1'b1;
        step();
        push("al_bit0", 0);    chk(32'(bit_idx));
        push("al_werr", 0);    chk(32'(word_err));
        sync_in = 1'b0;

        // Async reset mid-word while stats are non-zero.
        steps(4);
        src_active = 3'b011;
        step();
        src_active = '0;
        push("pre_rst_cont", 1); chk(32'(contention));
        push("pre_rst_owner", 2); chk(32'(owner));
        #2 PWO = 1'b1;
        #1;
        chk_reset_state("arst");
        #1 PWO = 1'b0;
        steps(3);
        push("arst_nolock", 0); chk(32'(locked));
        push("arst_bit", 0);    chk(32'(bit_idx));
        sync_in = 1'b1;
        step();
        push("arst_relock", 1); chk(32'(locked));
        sync_in = 1'b0;

        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hp_bus_fabric.md
HP_BUS_FABRIC -- requirements
Module: hp_bus_fabric

Interface
REQ-001 Parameters, one per line as name, default, meaning:
- N_SRC, 3, number of internal bus drivers (ROM count; values 1..8).
- WORD_LEN, 56, bit times per word.
- CNT_W, 8, contention counter width.
- KEEP_CYC, 1, bus-keeper hold cycles (0 = no keeper).
REQ-002 One clock; reset is asynchronous and active-high; the clock port is PHI2 and the reset port is PWO.
REQ-003 Ports, one per line as name, direction, width, meaning:
- PHI2  in  1  clock.
- PWO  in  1  async active-high reset.
- src_active  in  N_SRC  per-source drive request.
- src_drive  in  N_SRC  per-source bit value.
- src_en  in  N_SRC  debug enable per source; 0 = source ignored.
- ext_in  in  1  external pin value.
- sync_in  in  1  global SYNC.
- clr_stat  in  1  clear statistics.
- bus_out  out  1  resolved bus bit.
- bus_oe  out  1  pad output enable.
- owner  out  4  registered winner index+1 (0 = none).
- contention  out  1  sticky multi-driver flag.
- contention_cnt  out  CNT_W  contention cycle count.
- bit_idx  out  6  bit time within word.
- locked  out  1  word timing locked to SYNC.
- word_err  out  1  sticky SYNC misalignment flag.

Function
REQ-004 Qualified request q[i] = src_active[i] & src_en[i]; the winner is the highest i with q[i]=1.
REQ-005 With any q set: bus_out = src_drive[winner] and bus_oe = 1, combinationally in the same cycle.
REQ-006 With no q set: bus_oe = 0, and bus_out = the last driven value for KEEP_CYC cycles after the last driven cycle, then ext_in; KEEP_CYC=0 gives ext_in immediately.
REQ-007 owner updates every cycle to winner+1 (0 if none), one-cycle latency.
REQ-008 Two or more q set in a cycle counts as contention: contention sets on the next edge; contention_cnt increments and saturates at all-ones.
REQ-009 clr_stat clears contention, contention_cnt and word_err on the next edge; if clr_stat coincides with contention, the result is cnt=1, flag=1.
REQ-010 SYNC rising edge is detected against a registered copy of sync_in.
REQ-011 State machine UNLOCKED/LOCKED:
- UNLOCKED: on a SYNC rise, go to LOCKED with bit_idx=0 on the next edge.
- LOCKED: bit_idx increments and wraps WORD_LEN-1 -> 0.
- LOCKED: a SYNC rise while bit_idx != WORD_LEN-1 sets word_err and re-aligns bit_idx to 0; the state stays LOCKED.
REQ-012 In UNLOCKED, bit_idx holds 0; locked = (state == LOCKED).
REQ-013 src_en deasserting mid-word takes effect combinationally; no glitch-filtering is required.

Reset
REQ-014 PWO asserted forces the following state immediately, independent of PHI2:
- state UNLOCKED, bit_idx 0, owner 0.
- contention 0, contention_cnt 0, word_err 0.
- keeper value 0, keeper counter 0, sync register 0.
REQ-015 During reset, bus_out/bus_oe still follow REQ-005 combinationally; with no q set, bus_out = ext_in.
REQ-016 Reset release mid-word requires a fresh SYNC rise before locked asserts.

Structure
REQ-017 Shared package hp_bus_pkg holds the UNLOCKED/LOCKED state type, default WORD_LEN=56 and the owner-width constant.
REQ-018 Sub-module hp_bus_prio_enc (N_SRC-wide highest-index priority encoder with valid and multi-hit outputs) is instantiated once.
REQ-019 No tri-state logic; all bus resolution is by mux.

Verification
REQ-020 Priority: N_SRC=3, q=3'b011 with drive=3'b001 -> bus_out=0, bus_oe=1, owner=2 next cycle, contention=1, cnt=1.
REQ-021 Keeper: KEEP_CYC=1, last driven 1, then q=0 with ext_in=0 -> bus_out=1 for one cycle, then 0; bus_oe=0 throughout.
REQ-022 Lock: SYNC rise after reset -> locked=1, bit_idx=0 next edge; after 55 further cycles bit_idx=55, then wraps to 0.
REQ-023 Misalignment: SYNC rise at bit_idx=20 while LOCKED -> word_err=1, bit_idx=0 next edge.
REQ-024 Saturation/clear: CNT_W=4 with 20 contention cycles -> cnt=15; clr_stat on a contention cycle -> cnt=1, contention=1.
REQ-025 Async reset: PWO pulsed mid-word between PHI2 edges -> all REQ-014 values immediately, locked=0 until the next SYNC rise.
